program_counter_stage_btb: RTL and testbench

//  Parametrised fetch-side PC stage with a direct-mapped branch target buffer (BTB) and 2-bit predictors.

---
 rtl/program_counter_stage_btb.sv | 130 +++++++++++++
 tb/tb_program_counter_stage_btb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/program_counter_stage_btb.sv
// Fetch PC stage with a direct-mapped BTB and a 2-bit saturating predictor per entry.
// Latency: prediction is combinational from the registered PC; a redirect lands on the next edge.
// Backpressure: stall_fetch holds the PC, a mispredict overrides the stall, and BTB training ignores the stall.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   stall_fetch             hold the current fetch PC
//   redirect_*              branch/jump resolved in execute, with the prediction it carried
//   pc                      registered fetch PC
//   pc_pred_taken/_target   prediction for pc
//   clear_decoding_stage    flush decode register on mispredict
//   clear_execution_stage   flush execute register on mispredict
//   mispredict_count        saturating mispredict counter
module program_counter_stage_btb #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                    BTB_ENTRIES  = 16,
   parameter int                    MISS_CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall_fetch,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_ex,
   input  logic                  redirect_taken,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   input  logic                  redirect_pred_taken,
   input  logic [ADDR_WIDTH-1:0] redirect_pred_target,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  pc_pred_taken,
   output logic [ADDR_WIDTH-1:0] pc_pred_target,
   output logic                  clear_decoding_stage,
   output logic                  clear_execution_stage,
   output logic [MISS_CNT_W-1:0] mispredict_count
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
   localparam int WA_W  = ADDR_WIDTH - 2;
   localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

   // Targets are kept as word addresses; the two zero LSBs are not stored.
   logic [ADDR_WIDTH-1:0]               pc_q;
   logic [BTB_ENTRIES-1:0]              btb_vld;
   logic [BTB_ENTRIES-1:0][TAG_W-1:0]   btb_tag;
   logic [BTB_ENTRIES-1:0][WA_W-1:0]    btb_tgt;
   logic [BTB_ENTRIES-1:0][1:0]         btb_ctr;
   logic [MISS_CNT_W-1:0]               miss_cnt_q;

   logic [IDX_W-1:0]      f_idx, u_idx;
   logic [TAG_W-1:0]      f_tag, u_tag;
   logic                  f_hit, u_hit, mispredict;
   logic [ADDR_WIDTH-1:0] pc_plus4, ex_plus4, pc_nxt;
   logic [1:0]            u_ctr;
   logic                  unused_low_bits;

   // Fetch-side lookup
   assign f_idx          = pc_q[IDX_W+1:2];
   assign f_tag          = pc_q[ADDR_WIDTH-1:IDX_W+2];
   assign f_hit          = btb_vld[f_idx] && (btb_tag[f_idx] == f_tag);
   assign pc_plus4       = pc_q + FOUR;
   assign pc_pred_taken  = f_hit && btb_ctr[f_idx][1];
   assign pc_pred_target = f_hit ? {btb_tgt[f_idx], 2'b00} : pc_plus4;
   assign pc             = pc_q;

   // Execute-side update lookup
   assign u_idx    = redirect_pc_ex[IDX_W+1:2];
   assign u_tag    = redirect_pc_ex[ADDR_WIDTH-1:IDX_W+2];
   assign u_hit    = btb_vld[u_idx] && (btb_tag[u_idx] == u_tag);
   assign u_ctr    = btb_ctr[u_idx];
   assign ex_plus4 = redirect_pc_ex + FOUR;

   // Only the word address of the target is compared; gating with rst_n keeps
   // the flushes low while reset is held.
   assign mispredict = rst_n && redirect_valid &&
                       ((redirect_taken != redirect_pred_taken) ||
                        (redirect_taken &&
                         (redirect_target[ADDR_WIDTH-1:2] != redirect_pred_target[ADDR_WIDTH-1:2])));

   assign clear_decoding_stage  = mispredict;
   assign clear_execution_stage = mispredict;
   assign mispredict_count      = miss_cnt_q;

   assign unused_low_bits = ^{redirect_target[1:0], redirect_pred_target[1:0], ex_plus4[1:0]};

   always_comb begin
      pc_nxt = pc_q;
      if (mispredict) begin
         pc_nxt = redirect_taken ? {redirect_target[ADDR_WIDTH-1:2], 2'b00}
                                 : {ex_plus4[ADDR_WIDTH-1:2], 2'b00};
      end else if (!stall_fetch) begin
         pc_nxt = pc_pred_taken ? pc_pred_target : pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VECTOR;
         miss_cnt_q <= '0;
      end else begin
         pc_q <= pc_nxt;
         if (mispredict && (miss_cnt_q != '1))
            miss_cnt_q <= miss_cnt_q + MISS_CNT_W'(1);
      end
   end

   // BTB training; the fetch lookup above sees these contents one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btb_vld <= '0;
         btb_tag <= '0;
         btb_tgt <= '0;
         btb_ctr <= {BTB_ENTRIES{2'b01}};
      end else if (redirect_valid) begin
         if (redirect_taken) begin
            btb_tgt[u_idx] <= redirect_target[ADDR_WIDTH-1:2];
            if (u_hit) begin
               btb_ctr[u_idx] <= (u_ctr == 2'b11) ? u_ctr : u_ctr + 2'd1;
            end else begin
               btb_vld[u_idx] <= 1'b1;
               btb_tag[u_idx] <= u_tag;
               btb_ctr[u_idx] <= 2'b10;
            end
         end else if (u_hit) begin
            btb_ctr[u_idx] <= (u_ctr == 2'b00) ? u_ctr : u_ctr - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_program_counter_stage_btb.sv
// Directed bench for program_counter_stage_btb: training, hysteresis, stall, aliasing, wrap, saturation, reset.
// Latency: each vector is checked mid-cycle for the combinational outputs and 1 ns after the edge for the PC.
// Backpressure: stall vectors check that the PC holds and that a mispredict still overrides the stall.
module tb_program_counter_stage_btb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_fetch = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc_ex = '0;
   logic        redirect_taken = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        redirect_pred_taken = 1'b0;
   logic [31:0] redirect_pred_target = '0;
   logic [31:0] pc;
   logic        pc_pred_taken;
   logic [31:0] pc_pred_target;
   logic        clear_decoding_stage;
   logic        clear_execution_stage;
   logic [3:0]  mispredict_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   program_counter_stage_btb #(
      .ADDR_WIDTH   (32),
      .RESET_VECTOR (32'h0),
      .BTB_ENTRIES  (16),
      .MISS_CNT_W   (4)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .stall_fetch           (stall_fetch),
      .redirect_valid        (redirect_valid),
      .redirect_pc_ex        (redirect_pc_ex),
      .redirect_taken        (redirect_taken),
      .redirect_target       (redirect_target),
      .redirect_pred_taken   (redirect_pred_taken),
      .redirect_pred_target  (redirect_pred_target),
      .pc                    (pc),
      .pc_pred_taken         (pc_pred_taken),
      .pc_pred_target        (pc_pred_target),
      .clear_decoding_stage  (clear_decoding_stage),
      .clear_execution_stage (clear_execution_stage),
      .mispredict_count      (mispredict_count)
   );

   typedef struct {
      bit          stall;
      bit          rv;
      logic [31:0] pc_ex;
      bit          taken;
      logic [31:0] tgt;
      bit          ptaken;
      logic [31:0] ptgt;
      logic [31:0] e_pc;
      bit          e_pt;
      logic [31:0] e_ptgt;
      bit          e_clr;
      logic [31:0] e_next;
      int          e_cnt;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input bit stall, input bit rv, input logic [31:0] pc_ex,
                               input bit taken, input logic [31:0] tgt, input bit ptaken,
                               input logic [31:0] ptgt, input logic [31:0] e_pc, input bit e_pt,
                               input logic [31:0] e_ptgt, input bit e_clr,
                               input logic [31:0] e_next, input int e_cnt);
      vec_t v;
      v.stall = stall; v.rv = rv; v.pc_ex = pc_ex; v.taken = taken; v.tgt = tgt;
      v.ptaken = ptaken; v.ptgt = ptgt; v.e_pc = e_pc; v.e_pt = e_pt; v.e_ptgt = e_ptgt;
      v.e_clr = e_clr; v.e_next = e_next; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Entered 1 ns after a rising edge; leaves 1 ns after the next one.
   task automatic apply(input vec_t v, input string tag);
      stall_fetch          = v.stall;
      redirect_valid       = v.rv;
      redirect_pc_ex       = v.pc_ex;
      redirect_taken       = v.taken;
      redirect_target      = v.tgt;
      redirect_pred_taken  = v.ptaken;
      redirect_pred_target = v.ptgt;
      #2;
      chk({tag, " pc"}, pc, v.e_pc);
      chk({tag, " pred_taken"}, 32'(pc_pred_taken), 32'(v.e_pt));
      chk({tag, " pred_target"}, pc_pred_target, v.e_ptgt);
      chk({tag, " clear_dec"}, 32'(clear_decoding_stage), 32'(v.e_clr));
      chk({tag, " clear_ex"}, 32'(clear_execution_stage), 32'(v.e_clr));
      @(posedge clk);
      #1;
      chk({tag, " next_pc"}, pc, v.e_next);
      chk({tag, " count"}, 32'(mispredict_count), v.e_cnt[31:0]);
   endtask

   initial begin
      vec_t sv;
      int   exp_cnt;

      //        st rv pc_ex         tk tgt           ptk ptgt        e_pc          ept e_ptgt        clr e_next        cnt
      // T1 sequential fetch from reset
      vq.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'h0,        0, 32'h4,        0, 32'h4,        0));
      vq.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'h4,        0, 32'h8,        0, 32'h8,        0));
      vq.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'h8,        0, 32'hC,        0, 32'hC,        0));
      vq.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'hC,        0, 32'h10,       0, 32'h10,       0));
      // T2 first taken branch allocates, then 0x10 predicts taken
      vq.push_back(mk(0, 1, 32'h10,       1, 32'h40,       0, 32'h0,   32'h10,       0, 32'h14,       1, 32'h40,       1));
      vq.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'h40,       0, 32'h44,       0, 32'h44,       1));
      vq.push_back(mk(0, 1, 32'hC,        0, 32'h0,        1, 32'h0,   32'h44,       0, 32'h48,       1, 32'h10,       2));
      vq.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'h10,       1, 32'h40,       0, 32'h40,       2));
      // T3 correct taken -> ctr 11, then two not-taken resolutions
      vq.push_back(mk(0, 1, 32'h10,       1, 32'h40,       1, 32'h40,  32'h40,       0, 32'h44,       0, 32'h44,       2));
      vq.push_back(mk(0, 1, 32'hC,        0, 32'h0,        1, 32'h0,   32'h44,       0, 32'h48,       1, 32'h10,       3));
      vq.push_back(mk(0, 1, 32'h10,       0, 32'h0,        1, 32'h40,  32'h10,       1, 32'h40,       1, 32'h14,       4));
      vq.push_back(mk(0, 1, 32'hC,        0, 32'h0,        1, 32'h0,   32'h14,       0, 32'h18,       1, 32'h10,       5));
      vq.push_back(mk(0, 1, 32'h10,       0, 32'h0,        1, 32'h40,  32'h10,       1, 32'h40,       1, 32'h14,       6));
      vq.push_back(mk(0, 1, 32'hC,        0, 32'h0,        1, 32'h0,   32'h14,       0, 32'h18,       1, 32'h10,       7));
      vq.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'h10,       0, 32'h40,       0, 32'h14,       7));
      // T4 stall holds, mispredict overrides stall
      vq.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'h14,       0, 32'h18,       0, 32'h14,       7));
      vq.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'h14,       0, 32'h18,       0, 32'h14,       7));
      vq.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'h14,       0, 32'h18,       0, 32'h14,       7));
      vq.push_back(mk(1, 1, 32'h30,       1, 32'h80,       0, 32'h0,   32'h14,       0, 32'h18,       1, 32'h80,       8));
      // T5 alias 0x50 replaces 0x10's entry
      vq.push_back(mk(0, 1, 32'h50,       1, 32'h200,      0, 32'h0,   32'h80,       0, 32'h84,       1, 32'h200,      9));
      vq.push_back(mk(0, 1, 32'hC,        0, 32'h0,        1, 32'h0,   32'h200,      0, 32'h204,      1, 32'h10,      10));
      vq.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'h10,       0, 32'h14,       0, 32'h14,      10));
      // target low bits ignored; then wrong predicted target
      vq.push_back(mk(0, 1, 32'h50,       1, 32'h203,      1, 32'h200, 32'h14,       0, 32'h18,       0, 32'h18,      10));
      vq.push_back(mk(0, 1, 32'h50,       1, 32'h300,      1, 32'h200, 32'h18,       0, 32'h1C,       1, 32'h300,     11));
      // wrap of PC+4 and of REDIRECT_PC_EX+4
      vq.push_back(mk(0, 1, 32'h60,       1, 32'hFFFFFFFC, 0, 32'h0,   32'h300,      0, 32'h304,      1, 32'hFFFFFFFC, 12));
      vq.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,       12));
      vq.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 32'h0,        1, 32'h0,   32'h0,        0, 32'h4,        1, 32'h0,       13));

      // reset state
      repeat (2) @(posedge clk);
      #3;
      chk("reset pc", pc, 32'h0);
      chk("reset pred_taken", 32'(pc_pred_taken), 32'h0);
      chk("reset count", 32'(mispredict_count), 32'h0);
      chk("reset clear", 32'(clear_decoding_stage), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

      // counter saturation: 20 forced mispredicts, 4-bit count holds at F
      exp_cnt = 13;
      for (int i = 0; i < 20; i++) begin
         exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
         sv = mk(0, 1, 32'hC, 0, 32'h0, 1, 32'h0, (i == 0) ? 32'h0 : 32'h10, 0,
                 (i == 0) ? 32'h4 : 32'h14, 1, 32'h10, exp_cnt);
         apply(sv, $sformatf("sat%0d", i));
      end

      // T6 train 0x10 again, then asynchronous reset between edges
      apply(mk(0, 1, 32'h10, 1, 32'h40, 0, 32'h0, 32'h10, 0, 32'h14, 1, 32'h40, 15), "t6a");
      apply(mk(0, 1, 32'hC,  0, 32'h0,  1, 32'h0, 32'h40, 0, 32'h44, 1, 32'h10, 15), "t6b");
      redirect_valid = 1'b1; redirect_pc_ex = 32'hC; redirect_taken = 1'b0;
      redirect_pred_taken = 1'b1; stall_fetch = 1'b0;
      #2;
      chk("t6 hit pred_taken", 32'(pc_pred_taken), 32'h1);
      chk("t6 hit pred_target", pc_pred_target, 32'h40);
      chk("t6 pre-reset clear", 32'(clear_decoding_stage), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t6 async pc", pc, 32'h0);
      chk("t6 async clear_dec", 32'(clear_decoding_stage), 32'h0);
      chk("t6 async clear_ex", 32'(clear_execution_stage), 32'h0);
      chk("t6 async count", 32'(mispredict_count), 32'h0);
      @(posedge clk);
      #1;
      chk("t6 held pc", pc, 32'h0);
      rst_n = 1'b1;
      apply(mk(0, 1, 32'hC, 0, 32'h0, 1, 32'h0, 32'h0,  0, 32'h4,  1, 32'h10, 1), "t6c");
      apply(mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h10, 0, 32'h14, 0, 32'h14, 1), "t6d");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
